decode_execute: RTL and testbench
=================================

DECODE_EXECUTE -- requirements
Module: decode_execute

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-003 instruction  input  8  instruction fetched at the current program-counter address, valid in the same cycle as that address.
REQ-004 Branch  output  1  combinational; 1 = the program counter loads address + jump_value + 1 at the next edge.
REQ-005 jump_value  output  8  combinational; two's-complement offset, 8'h00 whenever Branch = 0.
REQ-006 result  output  8  registered; value of the last OUT instruction.
REQ-007 result_valid  output  1  registered; single-cycle pulse for each executed OUT.
REQ-008 halted  output  1  registered; 1 while the FSM is in HALT.
REQ-009 retired  output  16  registered; count of executed non-HALT instructions.

Function
REQ-010 Field decode SHALL be: op = [7:6], ra = [5:4], rb = [3:2], rd = [1:0], imm4 = [3:0].
REQ-011 The register file SHALL be 4 x 8 bit: R0 to R3, all readable and writable, with R0 not hard-wired.
REQ-012 ADD (op 00) SHALL write R[rd] <= R[ra] + R[rb] modulo 256 at the edge, with no carry or flag.
REQ-013 LI (op 01) SHALL write R[ra] <= sign-extend(imm4) at the edge, giving a range of 8'hF8 to 8'h07.
REQ-014 BNZ (op 10) SHALL drive Branch = 1 and jump_value = sign-extend(imm4) in the same cycle if R[ra] != 0; otherwise Branch = 0 and jump_value = 0; no register is written.
REQ-015 OUT (op 11, imm4 != 4'hF) SHALL load result <= R[ra] and pulse result_valid = 1 for one cycle.
REQ-016 HALT (op 11, imm4 = 4'hF) SHALL drive Branch = 1 and jump_value = 8'hFF in that cycle, and enter HALT at the edge.
  - With jump_value = 8'hFF, the address wraps to itself, so the PC freezes.
REQ-017 The FSM states SHALL be RUN and HALT:
  - RUN -> HALT only on a HALT instruction.
  - HALT -> RUN only on reset.
  - No other transitions exist.
REQ-018 In HALT, the outputs SHALL be:
  - Branch = 1 and jump_value = 8'hFF every cycle.
  - instruction is ignored.
  - No register writes occur, result_valid = 0, and retired holds.
REQ-019 Read-during-write: operands SHALL come from register state before the edge.
  - An instruction reading the register written by the previous instruction sees the new value.
  - No bypass within a cycle is required.
REQ-020 ADD with rd equal to ra or rb SHALL use the pre-edge operands.
REQ-021 retired SHALL increment by 1 per executed ADD, LI, BNZ (taken or not) or OUT, and saturate at 16'hFFFF.
REQ-022 BNZ with imm4 = 4'hF SHALL give jump_value = 8'hFF, so the address stays unchanged while R[ra] != 0; this is legal and is not HALT.
REQ-023 The branch target SHALL wrap modulo 256; the wrap is handled by the program counter.

Reset
REQ-024 On a reset edge the block SHALL clear all of the following:
  - R0 to R3 = 0, FSM = RUN.
  - result = 0, result_valid = 0, halted = 0, retired = 0.
REQ-025 While reset = 1, Branch = 0 and jump_value = 0 regardless of instruction.
REQ-026 While reset = 1, the instruction SHALL NOT write registers.
REQ-027 Reset asserted in HALT or mid-program SHALL return the block to RUN at the next edge, with no write from the instruction present in that cycle.

Structure
REQ-028 The opcode values, the HALT imm4 code (4'hF) and the FSM state encodings SHALL be defined in a shared include/package used by the assembler tests and the RTL.
REQ-029 The register file SHALL be a sub-module reg_file with:
  - two combinational read ports;
  - one synchronous write port (we, waddr, wdata);
  - synchronous reset.
REQ-030 The decode logic and the branch output logic SHALL stay in decode_execute.
REQ-031 The bench SHALL instantiate decode_execute with the existing program counter and a 256 x 8 combinational ROM.

Verification
REQ-032 Reset, then LI R1,3 and LI R2,-2 (8'h53, 8'h6E), then ADD R3=R1+R2 (8'h1B) -> R3 = 8'h01 and retired = 3.
REQ-033 Countdown loop: LI R0,3; LI R1,-1; ADD R0=R0+R1 at addr 2; BNZ R0,-2 at addr 3 -> Branch taken twice back to addr 2, then falls through, with R0 = 0.
REQ-034 OUT R3 after R3 = 8'h7F -> result = 8'h7F and a 1-cycle result_valid pulse; a second OUT R3 pulses again with the same value.
REQ-035 HALT at addr 5 -> halted = 1, read_address stays 5 for 20 cycles, Branch = 1, jump_value = 8'hFF, retired frozen.
REQ-036 Reset asserted during HALT together with an ADD on instruction -> RUN, all registers 0, address 0, no write.
REQ-037 ADD R0=R0+R0 with R0 = 8'h80 -> R0 = 8'h00 (wrap); a following BNZ R0 is not taken (Branch = 0).

Source files
------------

// File: rtl/decode_execute_pkg.sv
// Shared encodings for the decode_execute core: opcodes, HALT code, FSM states.
// Also used by the assembler tests.
package decode_execute_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpLi  = 2'b01,
    OpBnz = 2'b10,
    OpOut = 2'b11
  } opcode_e;

  // OUT with this imm4 is HALT
  localparam logic [3:0] HaltImm = 4'hF;

  // Offset that makes address + offset + 1 wrap back onto the address
  localparam logic [7:0] JumpSelf = 8'hFF;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } state_e;

  function automatic logic [7:0] sext4(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

endpackage

// File: rtl/decode_execute_reg_file.sv
// 4 x 8 register file: two combinational read ports, one synchronous write port.
// Synchronous reset clears all entries and takes priority over a write.
module reg_file (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_b,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0] regs_q [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/decode_execute.sv
// Single-cycle decode/execute core with RUN/HALT FSM, branch outputs to an
// external program counter, OUT result register and a saturating retire counter.
module decode_execute
  import decode_execute_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instruction,
  output logic        Branch,
  output logic [7:0]  jump_value,
  output logic [7:0]  result,
  output logic        result_valid,
  output logic        halted,
  output logic [15:0] retired
);

  opcode_e    op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [1:0] rd;
  logic [3:0] imm4;

  assign op   = opcode_e'(instruction[7:6]);
  assign ra   = instruction[5:4];
  assign rb   = instruction[3:2];
  assign rd   = instruction[1:0];
  assign imm4 = instruction[3:0];

  state_e      state_q, state_d;
  logic [7:0]  result_q;
  logic        result_valid_q;
  logic [15:0] retired_q;

  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       out_fire;
  logic       retire;

  reg_file u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (ra),
    .rdata_a (rdata_a),
    .raddr_b (rb),
    .rdata_b (rdata_b),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata)
  );

  always_comb begin
    state_d    = state_q;
    Branch     = 1'b0;
    jump_value = 8'h00;
    we         = 1'b0;
    waddr      = rd;
    wdata      = 8'h00;
    out_fire   = 1'b0;
    retire     = 1'b0;

    // Reset masks everything: no branch, no write, no state change
    if (!reset) begin
      unique case (state_q)
        StHalt: begin
          Branch     = 1'b1;
          jump_value = JumpSelf;
        end
        StRun: begin
          unique case (op)
            OpAdd: begin
              we     = 1'b1;
              waddr  = rd;
              wdata  = rdata_a + rdata_b;
              retire = 1'b1;
            end
            OpLi: begin
              we     = 1'b1;
              waddr  = ra;
              wdata  = sext4(imm4);
              retire = 1'b1;
            end
            OpBnz: begin
              if (rdata_a != 8'h00) begin
                Branch     = 1'b1;
                jump_value = sext4(imm4);
              end
              retire = 1'b1;
            end
            OpOut: begin
              if (imm4 == HaltImm) begin
                Branch     = 1'b1;
                jump_value = JumpSelf;
                state_d    = StHalt;
              end else begin
                out_fire = 1'b1;
                retire   = 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      retired_q      <= 16'h0000;
    end else begin
      state_q        <= state_d;
      result_valid_q <= out_fire;
      if (out_fire) begin
        result_q <= rdata_a;
      end
      if (retire && (retired_q != 16'hFFFF)) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign retired      = retired_q;
  assign halted       = (state_q == StHalt);

endmodule

// File: tb/tb_decode_execute.sv
// Bench for decode_execute: program counter plus 256 x 8 combinational ROM,
// a table of single-step vectors and hand-written multi-cycle programs.
module tb_decode_execute;

  logic        clk;
  logic        reset;
  logic [7:0]  instruction;
  logic        Branch;
  logic [7:0]  jump_value;
  logic [7:0]  result;
  logic        result_valid;
  logic        halted;
  logic [15:0] retired;

  logic [7:0] pc;
  logic [7:0] rom [256];

  int n_pass;
  int n_total;

  decode_execute dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .Branch       (Branch),
    .jump_value   (jump_value),
    .result       (result),
    .result_valid (result_valid),
    .halted       (halted),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter: address + jump_value + 1 on a branch, wrapping modulo 256
  always_ff @(posedge clk) begin
    if (reset) pc <= 8'h00;
    else if (Branch) pc <= pc + jump_value + 8'd1;
    else pc <= pc + 8'd1;
  end

  assign instruction = rom[pc];

  typedef struct {
    logic [7:0]  instr;
    logic        br;
    logic [7:0]  jv;
    logic [7:0]  res;
    logic        vld;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int taken;
    int bad;
    bit done;
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    clear_rom();

    // instr, Branch, jump_value, result, result_valid, retired (after the edge)
    vecs[0]  = '{8'h53, 1'b0, 8'h00, 8'h00, 1'b0, 16'd1};   // LI R1,3
    vecs[1]  = '{8'h6E, 1'b0, 8'h00, 8'h00, 1'b0, 16'd2};   // LI R2,-2
    vecs[2]  = '{8'h1B, 1'b0, 8'h00, 8'h00, 1'b0, 16'd3};   // ADD R3=R1+R2 -> 01
    vecs[3]  = '{8'hF0, 1'b0, 8'h00, 8'h01, 1'b1, 16'd4};   // OUT R3
    vecs[4]  = '{8'h92, 1'b1, 8'h02, 8'h01, 1'b0, 16'd5};   // BNZ R1,+2 taken
    vecs[5]  = '{8'h43, 1'b0, 8'h00, 8'h01, 1'b0, 16'd6};   // LI R0,3
    vecs[6]  = '{8'h04, 1'b0, 8'h00, 8'h01, 1'b0, 16'd7};   // ADD R0=R0+R1 -> 06
    vecs[7]  = '{8'hC0, 1'b0, 8'h00, 8'h06, 1'b1, 16'd8};   // OUT R0
    vecs[8]  = '{8'h77, 1'b0, 8'h00, 8'h06, 1'b0, 16'd9};   // LI R3,7
    vecs[9]  = '{8'h68, 1'b0, 8'h00, 8'h06, 1'b0, 16'd10};  // LI R2,-8
    vecs[10] = '{8'h3B, 1'b0, 8'h00, 8'h06, 1'b0, 16'd11};  // ADD R3=R3+R2 -> FF
    vecs[11] = '{8'hF0, 1'b0, 8'h00, 8'hFF, 1'b1, 16'd12};  // OUT R3
    vecs[12] = '{8'hBF, 1'b1, 8'hFF, 8'hFF, 1'b0, 16'd13};  // BNZ R3,-1 (self loop)
    vecs[13] = '{8'h50, 1'b0, 8'h00, 8'hFF, 1'b0, 16'd14};  // LI R1,0
    vecs[14] = '{8'h95, 1'b0, 8'h00, 8'hFF, 1'b0, 16'd15};  // BNZ R1,+5 not taken
    vecs[15] = '{8'h3D, 1'b0, 8'h00, 8'hFF, 1'b0, 16'd16};  // ADD R1=R3+R3 -> FE
    vecs[16] = '{8'hD0, 1'b0, 8'h00, 8'hFE, 1'b1, 16'd17};  // OUT R1

    // Reset with HALT on the bus: no branch, no HALT entry
    tick();
    tick();
    rom[pc] = 8'hFF;
    #1;
    chk("reset_branch", {31'd0, Branch}, 32'd0);
    chk("reset_jump", {24'd0, jump_value}, 32'd0);
    tick();
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_retired", {16'd0, retired}, 32'd0);
    chk("reset_result", {24'd0, result}, 32'd0);
    chk("reset_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_pc", {24'd0, pc}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      rom[pc] = vecs[i].instr;
      #1;
      chk($sformatf("v%0d_branch", i), {31'd0, Branch}, {31'd0, vecs[i].br});
      chk($sformatf("v%0d_jump", i), {24'd0, jump_value}, {24'd0, vecs[i].jv});
      tick();
      chk($sformatf("v%0d_result", i), {24'd0, result}, {24'd0, vecs[i].res});
      chk($sformatf("v%0d_valid", i), {31'd0, result_valid}, {31'd0, vecs[i].vld});
      chk($sformatf("v%0d_retired", i), {16'd0, retired}, {16'd0, vecs[i].ret});
    end

    // Countdown loop, then OUT R0 and HALT at address 5
    clear_rom();
    rom[0] = 8'h43;  // LI R0,3
    rom[1] = 8'h5F;  // LI R1,-1
    rom[2] = 8'h04;  // ADD R0=R0+R1
    rom[3] = 8'h8E;  // BNZ R0,-2
    rom[4] = 8'hC0;  // OUT R0
    rom[5] = 8'hFF;  // HALT
    do_reset();
    taken = 0;
    done  = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (halted) done = 1'b1;
      else begin
        if (pc == 8'd3 && Branch) taken++;
        tick();
      end
    end
    chk("loop_reached_halt", {31'd0, done}, 32'd1);
    chk("loop_taken", taken, 32'd2);
    chk("loop_result", {24'd0, result}, 32'd0);
    chk("loop_retired", {16'd0, retired}, 32'd9);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (pc !== 8'd5 || Branch !== 1'b1 || jump_value !== 8'hFF || retired !== 16'd9 ||
          halted !== 1'b1 || result_valid !== 1'b0) bad++;
      tick();
    end
    chk("halt_hold_bad_cycles", bad, 32'd0);

    // Reset during HALT with an ADD present: no write, back to RUN at address 0
    reset   = 1'b1;
    rom[pc] = 8'h14;  // ADD R0=R1+R1
    #1;
    chk("halt_reset_branch", {31'd0, Branch}, 32'd0);
    chk("halt_reset_jump", {24'd0, jump_value}, 32'd0);
    tick();
    rom[0] = 8'hC0;
    rom[1] = 8'hD0;
    rom[2] = 8'hE0;
    rom[3] = 8'hF0;
    rom[4] = 8'hFF;
    reset  = 1'b0;
    chk("halt_reset_halted", {31'd0, halted}, 32'd0);
    chk("halt_reset_pc", {24'd0, pc}, 32'd0);
    chk("halt_reset_retired", {16'd0, retired}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      tick();
      chk($sformatf("reg%0d_cleared", r), {23'd0, result_valid, result}, 32'h100);
    end

    // 0x80 + 0x80 wraps to 0; double OUT; BNZ on zero falls through
    clear_rom();
    rom[0]  = 8'h48;  // LI R0,-8
    rom[1]  = 8'h6F;  // LI R2,-1
    rom[2]  = 8'h00;  // ADD R0=R0+R0 x4 -> 80
    rom[3]  = 8'h00;
    rom[4]  = 8'h00;
    rom[5]  = 8'h00;
    rom[6]  = 8'h0B;  // ADD R3=R0+R2 -> 7F
    rom[7]  = 8'hF0;  // OUT R3
    rom[8]  = 8'hF0;  // OUT R3
    rom[9]  = 8'h00;  // ADD R0=R0+R0 -> 00
    rom[10] = 8'h83;  // BNZ R0,+3
    rom[11] = 8'hC0;  // OUT R0
    rom[12] = 8'hFF;  // HALT
    do_reset();
    for (int c = 0; c < 7; c++) tick();
    chk("wrap_pc7", {24'd0, pc}, 32'd7);
    tick();
    chk("out1", {23'd0, result_valid, result}, 32'h17F);
    tick();
    chk("out2", {23'd0, result_valid, result}, 32'h17F);
    tick();
    chk("out_pulse_end", {23'd0, result_valid, result}, 32'h07F);
    chk("bnz_zero_branch", {31'd0, Branch}, 32'd0);
    chk("bnz_zero_jump", {24'd0, jump_value}, 32'd0);
    tick();
    chk("bnz_fallthrough_pc", {24'd0, pc}, 32'd11);
    tick();
    chk("out_wrapped_r0", {23'd0, result_valid, result}, 32'h100);
    tick();
    chk("final_halted", {31'd0, halted}, 32'd1);
    chk("final_retired", {16'd0, retired}, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
